// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file and its clear sequencer.
package regfile_pkg;

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    localparam int unsigned ZeroReg = 0;

    // LSB of port k inside a packed multi-port bus of per-port width w.
    function automatic int unsigned port_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback side bus of regfile_sb: packed read ports, write port, scoreboard and clear.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_pend;
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic                  pend_set;
    logic [ADDR_W-1:0]     pend_addr;
    logic                  clear_req;
    logic                  busy;

    modport master (
        output rd_addr, we, waddr, wdata, pend_set, pend_addr, clear_req,
        input  rd_data, rd_pend, busy
    );

    modport slave (
        input  rd_addr, we, waddr, wdata, pend_set, pend_addr, clear_req,
        output rd_data, rd_pend, busy
    );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: sweeps registers 1..N-1 to zero after reset or on a clear request.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              busy_o
);
    localparam logic [ADDR_W-1:0] PtrFirst = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PtrLast  = '1;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            ptr_q   <= PtrFirst;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clear_req_i) begin
                        state_q <= StClear;
                        ptr_q   <= PtrFirst;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    // Last register is written on this edge; ptr never wraps.
                    if (ptr_q == PtrLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= StClear;
                    ptr_q   <= PtrFirst;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we_o   = (state_q == StClear);
    assign clr_addr_o = ptr_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard and hardware clear sweep.
// Optional write-through bypass when REGFILE_BYPASS_EN is defined.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int unsigned       N     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RZero = ADDR_W'(ZeroReg);

    logic [DATA_W-1:0] mem_q [N];
    logic [N-1:0]      pend_q, pend_d;
    logic              busy, clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              idle_cmd, wr_en, set_en;

    regfile_clr_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clr_fsm (
        .clk        (clk),
        .rst        (rst),
        .clear_req_i(bus.clear_req),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (busy)
    );

    assign bus.busy = busy;

    // A clear request in IDLE drops any write or pend_set on the same edge.
    assign idle_cmd = !busy && !bus.clear_req;
    assign wr_en    = idle_cmd && bus.we && (bus.waddr != RZero);
    assign set_en   = idle_cmd && bus.pend_set && (bus.pend_addr != RZero);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_en) begin
            mem_q[bus.waddr] <= bus.wdata;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (!busy && bus.clear_req) begin
            pend_d = '0;
        end else begin
            if (wr_en)  pend_d[bus.waddr]     = 1'b0;
            if (set_en) pend_d[bus.pend_addr] = 1'b1;
        end
        pend_d[ZeroReg] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data;
        logic              pend;
        logic              byp;
        logic              byp_pend;

        assign ra = bus.rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
        assign byp      = wr_en && (ra == bus.waddr);
        assign byp_pend = set_en && (bus.pend_addr == bus.waddr);
`else
        assign byp      = 1'b0;
        assign byp_pend = 1'b0;
`endif

        always_comb begin
            data = mem_q[ra];
            pend = pend_q[ra];
            if (byp) begin
                data = bus.wdata;
                pend = byp_pend;
            end
            if (busy || ra == RZero) data = '0;
            if (busy) pend = 1'b0;
        end

        assign bus.rd_data[port_lsb(k, DATA_W) +: DATA_W] = data;
        assign bus.rd_pend[k]                             = pend;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (two read ports, 32x32).
module tb_regfile_sb;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();

    regfile_sb #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .NRD   (NR)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.rd_addr = {a1, a0};
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        step();
        bus.we = 1'b0;
    endtask

    // Counts cycles until busy drops, bounded.
    task automatic count_busy(input string tag, input int exp);
        int cnt;
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            step();
            cnt++;
        end
        check_val(tag, 32'(cnt), 32'(exp));
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 1; i < 32; i++) begin
            set_rd(AW'(i), AW'(0));
            check_val(tag, bus.rd_data[31:0], 32'h0);
            check_val({tag, "_pend"}, 32'(bus.rd_pend[0]), 32'h0);
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.we        = 1'b0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.pend_set  = 1'b0;
        bus.pend_addr = '0;
        bus.clear_req = 1'b0;
        bus.rd_addr   = {AW'(6), AW'(5)};

        // Reset outputs
        repeat (2) step();
        check_val("rst_busy", 32'(bus.busy), 32'h1);
        check_val("rst_rd_data", bus.rd_data[31:0], 32'h0);
        check_val("rst_rd_pend", 32'(bus.rd_pend), 32'h0);
        rst = 1'b0;
        count_busy("rst_busy_len", 31);
        check_all_zero("post_rst_zero");

        // Write/read
        wr(AW'(5), 32'hDEADBEEF);
        set_rd(AW'(5), AW'(0));
        check_val("wr_r5_p0", bus.rd_data[31:0], 32'hDEADBEEF);
        check_val("wr_r0_p1", bus.rd_data[63:32], 32'h0);
        wr(AW'(0), 32'hFFFFFFFF);
        set_rd(AW'(0), AW'(5));
        check_val("wr_r0_ignored", bus.rd_data[31:0], 32'h0);
        check_val("r5_p1", bus.rd_data[63:32], 32'hDEADBEEF);

        // Scoreboard set / clear / set-wins
        bus.pend_set  = 1'b1;
        bus.pend_addr = AW'(7);
        step();
        bus.pend_set = 1'b0;
        set_rd(AW'(7), AW'(8));
        check_val("pend_r7_set", 32'(bus.rd_pend), 32'h1);
        wr(AW'(7), 32'h12);
        set_rd(AW'(7), AW'(8));
        check_val("pend_r7_clr", 32'(bus.rd_pend), 32'h0);
        check_val("r7_data", bus.rd_data[31:0], 32'h12);
        bus.pend_set  = 1'b1;
        bus.pend_addr = AW'(9);
        wr(AW'(9), 32'h33);
        bus.pend_set = 1'b0;
        set_rd(AW'(8), AW'(9));
        check_val("pend_r9_setwins", 32'(bus.rd_pend), 32'h2);
        check_val("r9_data", bus.rd_data[63:32], 32'h33);
        pend_set_pulse_pend_r0();

        // Bypass / no bypass
        wr(AW'(3), 32'h11);
        bus.we    = 1'b1;
        bus.waddr = AW'(3);
        bus.wdata = 32'h55;
        set_rd(AW'(3), AW'(0));
`ifdef REGFILE_BYPASS_EN
        check_val("byp_same_cycle", bus.rd_data[31:0], 32'h55);
`else
        check_val("nobyp_old_val", bus.rd_data[31:0], 32'h11);
`endif
        check_val("byp_pend", 32'(bus.rd_pend[0]), 32'h0);
        step();
        bus.we = 1'b0;
        #1;
        check_val("r3_after_edge", bus.rd_data[31:0], 32'h55);

        // Fill then clear mid-use
        for (int i = 1; i < 32; i++) wr(AW'(i), 32'hA5A5A5A5);
        bus.pend_set  = 1'b1;
        bus.pend_addr = AW'(4);
        step();
        bus.pend_set = 1'b0;
        set_rd(AW'(31), AW'(4));
        check_val("fill_r31", bus.rd_data[31:0], 32'hA5A5A5A5);
        check_val("pend_r4_before_clr", 32'(bus.rd_pend), 32'h2);
        bus.clear_req = 1'b1;
        bus.we        = 1'b1;
        bus.waddr     = AW'(2);
        bus.wdata     = 32'h77;
        step();
        bus.clear_req = 1'b0;
        bus.waddr     = AW'(6);
        bus.wdata     = 32'h99;
        set_rd(AW'(6), AW'(4));
        check_val("clr_busy", 32'(bus.busy), 32'h1);
        check_val("busy_rd_data", bus.rd_data[31:0], 32'h0);
        check_val("busy_rd_pend", 32'(bus.rd_pend), 32'h0);
        step();
        bus.we = 1'b0;
        count_busy("clr_busy_len", 30);
        check_all_zero("post_clr_zero");

        // Reset mid-sweep restarts from ptr=1
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        #1;
        check_val("midsweep_rst_busy", 32'(bus.busy), 32'h1);
        step();
        rst = 1'b0;
        count_busy("midsweep_busy_len", 31);
        check_val("midsweep_idle", 32'(bus.busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // pend_set on r0 must never raise a pending bit.
    task automatic pend_set_pulse_pend_r0();
        bus.pend_set  = 1'b1;
        bus.pend_addr = AW'(0);
        step();
        bus.pend_set = 1'b0;
        set_rd(AW'(0), AW'(9));
        check_val("pend_r0_never", 32'(bus.rd_pend), 32'h2);
    endtask

endmodule
